// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer and the universal shift register it drives.
// Mode values match the register's mode input; state values are the sequencer FSM.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } sr_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    function automatic sr_mode_e shift_mode(input logic dir);
        return dir ? MODE_LEFT : MODE_RIGHT;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_counter.sv
// Down counter tracking how many bits of the current command are still to be shifted out.
// Load has priority over decrement; decrement saturates at zero.
module shift_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-mode universal shift register: load a word, stream bits out, pulse done.
// Defining SHIFT_SEQ_PARITY_EN adds an even-parity trailer bit after the data bits.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             sr_serial_in_left,
    output logic             sr_serial_in_right,
    input  logic [WIDTH-1:0] sr_q,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for a command, register held
    // LOAD   | parallel-load the latched word
    // SHIFT  | present one bit per cycle, shift when serial_ready
    // PARITY | present the even-parity trailer bit (parity build only)
    // DONE   | one-cycle completion pulse

`ifdef SHIFT_SEQ_PARITY_EN
    localparam seq_state_e POST_DATA = PARITY;
`else
    localparam seq_state_e POST_DATA = DONE;
`endif

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WIDTH);

    seq_state_e       state_q;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic             fill_q;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             parity_q;
`endif

    logic             accept;
    logic             shift_fire;
    logic             cur_bit;
    logic             cnt_zero;
    logic             cnt_last;
    logic [CNT_W-1:0] count_clamped;

    assign count_clamped = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
    assign cur_bit       = dir_q ? sr_q[WIDTH-1] : sr_q[0];
    assign accept        = cmd_valid && cmd_ready;
    assign shift_fire    = !reset && (state_q == SHIFT) && serial_ready;

    shift_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (accept),
        .load_val_i (count_clamped),
        .dec_i      (shift_fire),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q   <= cmd_data;
                        dir_q    <= cmd_dir;
                        fill_q   <= cmd_fill;
`ifdef SHIFT_SEQ_PARITY_EN
                        parity_q <= 1'b0;
`endif
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= cnt_zero ? POST_DATA : SHIFT;
                end
                SHIFT: begin
                    if (serial_ready) begin
`ifdef SHIFT_SEQ_PARITY_EN
                        parity_q <= parity_q ^ cur_bit;
`endif
                        if (cnt_last) begin
                            state_q <= POST_DATA;
                        end
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                PARITY: begin
                    if (serial_ready) begin
                        state_q <= DONE;
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Controls are forced inactive while reset is asserted so a mid-command reset stops shifting at once.
    always_comb begin
        cmd_ready    = 1'b0;
        sr_mode      = MODE_HOLD;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        done         = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                end
                LOAD: begin
                    sr_mode = MODE_LOAD;
                end
                SHIFT: begin
                    serial_valid = 1'b1;
                    serial_out   = cur_bit;
                    if (serial_ready) begin
                        sr_mode = shift_mode(dir_q);
                    end
                end
`ifdef SHIFT_SEQ_PARITY_EN
                PARITY: begin
                    serial_valid = 1'b1;
                    serial_out   = parity_q;
                end
`endif
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                    sr_mode = MODE_HOLD;
                end
            endcase
        end
    end

    assign sr_parallel_in     = data_q;
    assign sr_serial_in_left  = fill_q;
    assign sr_serial_in_right = fill_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench: directed commands push expected bits/completions, a negedge monitor checks them.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;
`ifdef SHIFT_SEQ_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic          cmd_dir;
    logic [CW-1:0] cmd_count;
    logic          cmd_fill;
    logic [1:0]    sr_mode;
    logic [W-1:0]  sr_parallel_in;
    logic          sr_serial_in_left;
    logic          sr_serial_in_right;
    logic [W-1:0]  sr_q;
    logic          serial_out;
    logic          serial_valid;
    logic          serial_ready;
    logic          done;

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_data           (cmd_data),
        .cmd_dir            (cmd_dir),
        .cmd_count          (cmd_count),
        .cmd_fill           (cmd_fill),
        .sr_mode            (sr_mode),
        .sr_parallel_in     (sr_parallel_in),
        .sr_serial_in_left  (sr_serial_in_left),
        .sr_serial_in_right (sr_serial_in_right),
        .sr_q               (sr_q),
        .serial_out         (serial_out),
        .serial_valid       (serial_valid),
        .serial_ready       (serial_ready),
        .done               (done)
    );

    // Universal shift register model driven by the sequencer
    logic [W-1:0] tb_q = '0;
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   tb_q <= {sr_serial_in_left, tb_q[W-1:1]};
            2'b10:   tb_q <= {tb_q[W-2:0], sr_serial_in_right};
            2'b11:   tb_q <= sr_parallel_in;
            default: tb_q <= tb_q;
        endcase
    end
    assign sr_q = tb_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    typedef struct {
        int           acc;
        int           lat;
        logic [W-1:0] q;
        logic         fill;
    } done_t;

    logic  exp_bits[$];
    done_t exp_done[$];
    int    bits_acc = 0;
    int    done_cnt = 0;

    // Monitor
    bit           busy = 0;
    bit           stalled_prev = 0;
    logic [W-1:0] q_prev = '0;
    done_t        d;
    always @(negedge clk) begin
        if (reset) begin
            busy = 0;
            stalled_prev = 0;
        end else begin
            if (busy) chk("ready_low_while_busy", cmd_ready, 0);
            if (cmd_valid && cmd_ready) busy = 1;
            if (serial_valid) begin
                if (serial_ready) begin
                    if (exp_bits.size() == 0) fail_now("unexpected_serial_bit");
                    else chk("serial_bit", serial_out, exp_bits.pop_front());
                    bits_acc++;
                end else begin
                    chk("stall_mode_hold", sr_mode, 2'b00);
                    if (exp_bits.size() != 0) chk("stall_bit_stable", serial_out, exp_bits[0]);
                    if (stalled_prev) chk("stall_q_held", tb_q, q_prev);
                end
            end
            stalled_prev = serial_valid && !serial_ready;
            q_prev = tb_q;
            if (done) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    d = exp_done.pop_front();
                    chk("done_latency", cyc + 1 - d.acc, d.lat);
                    chk("q_final", tb_q, d.q);
                    chk("fill_left", sr_serial_in_left, d.fill);
                    chk("fill_right", sr_serial_in_right, d.fill);
                end
                busy = 0;
                done_cnt++;
            end
        end
    end

    // seq lists the emitted bits left to right in output order; lat excludes the parity bit.
    typedef struct {
        logic [W-1:0]  data;
        logic          dir;
        logic [CW-1:0] cnt;
        logic          fill;
        logic [W-1:0]  seq;
        int            nb;
        logic [W-1:0]  q_end;
        int            lat;
        int            stall;
        bit            rst;
        bit            hold;
    } vec_t;

    vec_t vecs[9];
    vec_t v;
    int   acc;
    int   base;
    int   d0;
    bit   got;
    logic par;
    logic b;

    initial begin
        vecs[0] = '{4'b1010, 1'b0, 3'd4, 1'b0, 4'b0101, 4, 4'b0000, 6, 0, 1'b0, 1'b0};
        vecs[1] = '{4'b1010, 1'b1, 3'd4, 1'b1, 4'b1010, 4, 4'b1111, 6, 0, 1'b0, 1'b1};
        vecs[2] = '{4'b0011, 1'b0, 3'd2, 1'b0, 4'b1100, 2, 4'b0000, 4, 0, 1'b0, 1'b0};
        vecs[3] = '{4'b0110, 1'b0, 3'd7, 1'b1, 4'b0110, 4, 4'b1111, 6, 0, 1'b0, 1'b0};
        vecs[4] = '{4'b0011, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 4'b0011, 2, 0, 1'b0, 1'b0};
        vecs[5] = '{4'b1100, 1'b0, 3'd4, 1'b0, 4'b0011, 4, 4'b0000, 8, 2, 1'b0, 1'b0};
        vecs[6] = '{4'b1100, 1'b0, 3'd4, 1'b1, 4'b0000, 2, 4'b0000, 0, 0, 1'b1, 1'b0};
        vecs[7] = '{4'b0101, 1'b1, 3'd3, 1'b0, 4'b0100, 3, 4'b1000, 5, 0, 1'b0, 1'b0};
        vecs[8] = '{4'b1011, 1'b0, 3'd4, 1'b0, 4'b1101, 4, 4'b0000, 6, 0, 1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_dir = 1'b0;
        cmd_count = '0; cmd_fill = 1'b0; serial_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_sr_mode", sr_mode, 2'b00);
        chk("rst_serial_valid", serial_valid, 0);
        chk("rst_serial_out", serial_out, 0);
        chk("rst_done", done, 0);
        chk("rst_parallel_in", sr_parallel_in, 0);
        chk("rst_serial_in_left", sr_serial_in_left, 0);
        chk("rst_serial_in_right", sr_serial_in_right, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        for (int t = 0; t < 9; t++) begin
            v = vecs[t];
            d0 = done_cnt;
            @(posedge clk); #1;
            cmd_data = v.data; cmd_dir = v.dir; cmd_count = v.cnt; cmd_fill = v.fill;
            cmd_valid = 1'b1;
            got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cmd_ready) begin
                    got = 1;
                    acc = cyc + 1;
                    break;
                end
            end
            if (!got) begin
                fail_now("accept_timeout");
                cmd_valid = 1'b0;
                continue;
            end
            base = bits_acc;
            par = 1'b0;
            for (int j = 0; j < v.nb; j++) begin
                b = v.seq[W-1-j];
                exp_bits.push_back(b);
                par = par ^ b;
            end
            if (!v.rst) begin
                if (PAR != 0) exp_bits.push_back(par);
                exp_done.push_back('{acc, v.lat + PAR, v.q_end, v.fill});
            end
            @(posedge clk); #1;
            if (v.hold) cmd_data = ~v.data;
            else cmd_valid = 1'b0;

            if (v.stall > 0 || v.rst) begin
                got = 0;
                for (int i = 0; i < 40; i++) begin
                    if (bits_acc - base >= 2) begin
                        got = 1;
                        break;
                    end
                    @(posedge clk); #1;
                end
                if (!got) begin
                    fail_now("two_bits_timeout");
                end else if (v.rst) begin
                    reset = 1'b1;
                    @(posedge clk); #1 reset = 1'b0;
                    @(negedge clk);
                    chk("post_rst_idle_ready", cmd_ready, 1);
                    chk("post_rst_sr_mode", sr_mode, 2'b00);
                    chk("post_rst_done", done, 0);
                    chk("post_rst_bits_flushed", exp_bits.size(), 0);
                    exp_bits.delete();
                end else begin
                    serial_ready = 1'b0;
                    repeat (v.stall) @(posedge clk);
                    #1 serial_ready = 1'b1;
                end
            end

            if (!v.rst) begin
                got = 0;
                for (int i = 0; i < 60; i++) begin
                    if (done_cnt > d0) begin
                        got = 1;
                        break;
                    end
                    @(posedge clk); #1;
                end
                if (!got) fail_now("done_timeout");
                cmd_valid = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bits_outstanding", exp_bits.size(), 0);
        chk("dones_outstanding", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
